// File: rtl/cpu32_pkg.sv
// ============================================================================
// Module : cpu32_pkg
// Brief  : Shared types and default widths for the cpu32 memory sequencer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu32_pkg;

  localparam int c_default_aw = 32;
  localparam int c_default_dw = 32;

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_LATCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_DWAIT = 3'd3,
    ST_XDONE = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/mux2.sv
// ============================================================================
// Module : mux2
// Brief  : Two-input multiplexer; sel=1 picks b.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux2 #(
  parameter int W = 32
) (
  input  logic         sel,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  assign y = sel ? b : a;

endmodule

`default_nettype wire

// File: rtl/register.sv
// ============================================================================
// Module : register
// Brief  : Enabled holding register with synchronous active-high clear.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module register #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module : mem_arbiter
// Brief  : Multicycle sequencer for cpu32 sharing one RAM with an external
//          requester; externals are granted at instruction boundaries only.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
  import cpu32_pkg::*;
#(
  parameter int AW = c_default_aw,
  parameter int DW = c_default_dw
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_data,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_data_w,
  input  logic          d_we,
  input  logic          d_re,
  output logic [DW-1:0] d_data_r,
  output logic          cpu_en,
  input  logic          x_req,
  input  logic          x_we,
  input  logic [AW-1:0] x_addr,
  input  logic [DW-1:0] x_wdata,
  output logic [DW-1:0] x_rdata,
  output logic          x_ack,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_data_w,
  output logic          m_we,
  output logic          m_re,
  input  logic [DW-1:0] m_data_r
);

  state_t        r_state;
  state_t        w_next;
  logic          r_x_last;
  logic          w_x_last_next;
  logic [DW-1:0] r_ir;

  logic          w_x_grant;
  logic [AW-1:0] w_core_addr;
  logic [AW-1:0] w_src_addr;
  logic [DW-1:0] w_src_wdata;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;
  logic          w_we;
  logic          w_re;
  logic          w_cpu_en;
  logic          w_x_ack;

  // An external may only win a FETCH if the previous FETCH served the core.
  assign w_x_grant = (r_state == ST_FETCH) && x_req && !r_x_last;

  mux2 #(.W(AW)) u_core_addr_mux (
    .sel (r_state == ST_EXEC),
    .a   (i_addr),
    .b   (d_addr),
    .y   (w_core_addr)
  );

  mux2 #(.W(AW)) u_src_addr_mux (
    .sel (w_x_grant),
    .a   (w_core_addr),
    .b   (x_addr),
    .y   (w_src_addr)
  );

  mux2 #(.W(DW)) u_src_wdata_mux (
    .sel (w_x_grant),
    .a   (d_data_w),
    .b   (x_wdata),
    .y   (w_src_wdata)
  );

  register #(.W(DW)) u_ir (
    .clk (clk),
    .rst (reset),
    .en  (r_state == ST_LATCH),
    .d   (m_data_r),
    .q   (r_ir)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_FETCH;
      r_x_last <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_x_last <= w_x_last_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    w_x_last_next = r_x_last;
    w_addr        = '0;
    w_wdata       = '0;
    w_we          = 1'b0;
    w_re          = 1'b0;
    w_cpu_en      = 1'b0;
    w_x_ack       = 1'b0;
    case (r_state)
      ST_FETCH: begin
        w_addr = w_src_addr;
        if (w_x_grant) begin
          w_wdata       = w_src_wdata;
          w_we          = x_we;
          w_re          = !x_we;
          w_x_last_next = 1'b1;
          w_next        = ST_XDONE;
        end else begin
          w_re          = 1'b1;
          w_x_last_next = 1'b0;
          w_next        = ST_LATCH;
        end
      end
      ST_LATCH: begin
        w_next = ST_EXEC;
      end
      ST_EXEC: begin
        if (d_we) begin
          w_addr   = w_src_addr;
          w_wdata  = w_src_wdata;
          w_we     = 1'b1;
          w_cpu_en = 1'b1;
          w_next   = ST_FETCH;
        end else if (d_re) begin
          w_addr = w_src_addr;
          w_re   = 1'b1;
          w_next = ST_DWAIT;
        end else begin
          w_cpu_en = 1'b1;
          w_next   = ST_FETCH;
        end
      end
      ST_DWAIT: begin
        w_cpu_en = 1'b1;
        w_next   = ST_FETCH;
      end
      ST_XDONE: begin
        w_x_ack = 1'b1;
        w_next  = ST_FETCH;
      end
      default: begin
        w_next = ST_FETCH;
      end
    endcase
  end

  // Strobes are killed during reset so an aborted access neither commits nor retires.
  assign m_we     = w_we     & ~reset;
  assign m_re     = w_re     & ~reset;
  assign cpu_en   = w_cpu_en & ~reset;
  assign x_ack    = w_x_ack  & ~reset;
  assign m_addr   = w_addr;
  assign m_data_w = w_wdata;
  assign i_data   = r_ir;
  assign d_data_r = m_data_r;
  assign x_rdata  = m_data_r;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module : tb_mem_arbiter
// Brief  : Self-checking bench for mem_arbiter with a transaction-level model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] i_addr = '0;
  logic [DW-1:0] i_data;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_data_w = '0;
  logic          d_we = 1'b0;
  logic          d_re = 1'b0;
  logic [DW-1:0] d_data_r;
  logic          cpu_en;
  logic          x_req = 1'b0;
  logic          x_we = 1'b0;
  logic [AW-1:0] x_addr = '0;
  logic [DW-1:0] x_wdata = '0;
  logic [DW-1:0] x_rdata;
  logic          x_ack;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data_w;
  logic          m_we;
  logic          m_re;
  logic [DW-1:0] m_data_r = '0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .reset    (reset),
    .i_addr   (i_addr),
    .i_data   (i_data),
    .d_addr   (d_addr),
    .d_data_w (d_data_w),
    .d_we     (d_we),
    .d_re     (d_re),
    .d_data_r (d_data_r),
    .cpu_en   (cpu_en),
    .x_req    (x_req),
    .x_we     (x_we),
    .x_addr   (x_addr),
    .x_wdata  (x_wdata),
    .x_rdata  (x_rdata),
    .x_ack    (x_ack),
    .m_addr   (m_addr),
    .m_data_w (m_data_w),
    .m_we     (m_we),
    .m_re     (m_re),
    .m_data_r (m_data_r)
  );

  // Synchronous-read RAM the DUT talks to (word-indexed by addr[9:2]).
  logic [31:0] ram [0:255];
  always @(posedge clk) begin
    if (m_we) ram[m_addr[9:2]] <= m_data_w;
    if (m_re) m_data_r <= ram[m_addr[9:2]];
  end

  // Independent memory image maintained by the model.
  logic [31:0] mdl_mem [0:255];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] val);
    ram[idx]     = val;
    mdl_mem[idx] = val;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: each access is a transaction (instruction or external) with a cycle offset.
  int          ph = 0;
  bit          in_ext = 1'b0;
  bit          prev_ext = 1'b0;
  bit          x_is_rd = 1'b0;
  logic [31:0] mdl_ir = '0;
  logic [31:0] f_data, x_rd, l_rd;
  logic [31:0] e_addr, e_wd;
  logic        e_we, e_re, e_en, e_ack;

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_m_we", m_we, 0);
      chk("rst_m_re", m_re, 0);
      chk("rst_cpu_en", cpu_en, 0);
      chk("rst_x_ack", x_ack, 0);
      ph       = 0;
      prev_ext = 1'b0;
      mdl_ir   = '0;
    end else begin
      e_addr = '0; e_wd = '0; e_we = 1'b0; e_re = 1'b0; e_en = 1'b0; e_ack = 1'b0;
      chk("mdl_i_data", i_data, mdl_ir);
      if (ph == 0) begin
        in_ext   = x_req && !prev_ext;
        prev_ext = in_ext;
        if (in_ext) begin
          e_addr  = x_addr;
          e_wd    = x_wdata;
          e_we    = x_we;
          e_re    = !x_we;
          x_is_rd = !x_we;
          if (x_we) mdl_mem[x_addr[9:2]] = x_wdata;
          else      x_rd = mdl_mem[x_addr[9:2]];
        end else begin
          e_addr = i_addr;
          e_re   = 1'b1;
          f_data = mdl_mem[i_addr[9:2]];
        end
        ph = 1;
      end else if (in_ext) begin
        e_ack = 1'b1;
        if (x_is_rd) chk("mdl_x_rdata", x_rdata, x_rd);
        ph = 0;
      end else if (ph == 1) begin
        mdl_ir = f_data;
        ph     = 2;
      end else if (ph == 2) begin
        if (d_we) begin
          e_addr = d_addr;
          e_wd   = d_data_w;
          e_we   = 1'b1;
          e_en   = 1'b1;
          mdl_mem[d_addr[9:2]] = d_data_w;
          ph = 0;
        end else if (d_re) begin
          e_addr = d_addr;
          e_re   = 1'b1;
          l_rd   = mdl_mem[d_addr[9:2]];
          ph     = 3;
        end else begin
          e_en = 1'b1;
          ph   = 0;
        end
      end else begin
        e_en = 1'b1;
        chk("mdl_d_data_r", d_data_r, l_rd);
        ph = 0;
      end
      chk("mdl_m_addr", m_addr, e_addr);
      chk("mdl_m_data_w", m_data_w, e_wd);
      chk("mdl_m_we", m_we, e_we);
      chk("mdl_m_re", m_re, e_re);
      chk("mdl_cpu_en", cpu_en, e_en);
      chk("mdl_x_ack", x_ack, e_ack);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  int n_ack = 0;
  int n_en  = 0;

  initial begin
    for (int i = 0; i < 256; i++) preload(i, 32'h0A00_0000 + i);
    preload(0, 32'h1000_0001);
    preload(1, 32'h2000_0002);
    preload(2, 32'h3000_0003);
    preload(3, 32'h4000_0004);

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // ALU instruction from address 0: cycles 0..2
    @(negedge clk);
    chk("c0_m_re", m_re, 1);
    chk("c0_m_addr", m_addr, 32'h0);
    chk("c0_cpu_en", cpu_en, 0);
    step();
    @(negedge clk);
    chk("c1_cpu_en", cpu_en, 0);
    step();
    @(negedge clk);
    chk("c2_i_data", i_data, 32'h1000_0001);
    chk("c2_cpu_en", cpu_en, 1);

    // Store 0xDEADBEEF to 0x40: cycles 3..5
    step();
    i_addr = 32'h4; d_we = 1'b1; d_addr = 32'h40; d_data_w = 32'hDEAD_BEEF;
    step(); step();
    @(negedge clk);
    chk("st_m_we", m_we, 1);
    chk("st_m_addr", m_addr, 32'h40);
    chk("st_m_data_w", m_data_w, 32'hDEAD_BEEF);
    chk("st_cpu_en", cpu_en, 1);

    // Load from 0x40: cycles 6..9
    step();
    d_we = 1'b0; d_re = 1'b1; i_addr = 32'h8;
    step(); step();
    @(negedge clk);
    chk("ld_m_re", m_re, 1);
    chk("ld_m_addr", m_addr, 32'h40);
    chk("ld_exec_cpu_en", cpu_en, 0);
    step();
    @(negedge clk);
    chk("ld_d_data_r", d_data_r, 32'hDEAD_BEEF);
    chk("ld_dwait_cpu_en", cpu_en, 1);
    chk("ram_0x40", ram[16], 32'hDEAD_BEEF);

    // External read raised during EXEC of the next instruction: cycles 10..14
    step();
    d_re = 1'b0; i_addr = 32'h0;
    step(); step();
    x_req = 1'b1; x_we = 1'b0; x_addr = 32'h40;
    step();
    @(negedge clk);
    chk("xr_m_addr", m_addr, 32'h40);
    chk("xr_m_re", m_re, 1);
    chk("xr_grant_ack", x_ack, 0);
    step();
    @(negedge clk);
    chk("xr_x_ack", x_ack, 1);
    chk("xr_x_rdata", x_rdata, 32'hDEAD_BEEF);
    step();
    x_req = 1'b0;
    step(); step(); step();

    // Continuous external writes from cycle 18: ext/core alternate every 5 cycles
    x_req = 1'b1; x_we = 1'b1; x_addr = 32'h80; x_wdata = 32'hCAFE_F00D;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (x_ack) n_ack++;
      if (cpu_en) n_en++;
      step();
    end
    chk("alt_acks", n_ack, 3);
    chk("alt_cpu_en", n_en, 3);
    chk("ram_0x80", ram[32], 32'hCAFE_F00D);

    // Load aborted by reset in DWAIT: cycles 33..37
    x_req = 1'b0; x_we = 1'b0; i_addr = 32'h8; d_re = 1'b1; d_addr = 32'h40;
    step(); step();
    @(negedge clk);
    chk("ab_exec_m_re", m_re, 1);
    step();
    reset = 1'b1;
    @(negedge clk);
    chk("ab_cpu_en", cpu_en, 0);
    chk("ab_m_re", m_re, 0);
    step();
    i_addr = 32'hC; d_re = 1'b0;
    @(negedge clk);
    chk("ab_hold_cpu_en", cpu_en, 0);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("rel_m_re", m_re, 1);
    chk("rel_m_addr", m_addr, 32'hC);
    chk("rel_i_data", i_data, 32'h0);
    step(); step();
    @(negedge clk);
    chk("rel_i_data2", i_data, 32'h4000_0004);
    chk("rel_cpu_en", cpu_en, 1);
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Multicycle sequencer and memory arbiter that lets the non-pipelined cpu32 core run from a single-port, synchronous-read unified RAM shared with one external requester (debug/DMA). It sits between the core's split instruction/data ports and the RAM. It steps the core through fetch, latch, execute and optional load-wait phases, and tells the core when to retire through a clock-enable. External accesses are granted only at instruction boundaries, with alternating fairness.

## Interface
Parameters:
- `AW`, 32: address width.
- `DW`, 32: data width.

Ports:
- `clk`  in  1: clock; all state changes on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `i_addr`  in  AW: core PC / fetch address.
- `i_data`  out  DW: instruction to core (latched IR).
- `d_addr`  in  AW: core load/store address.
- `d_data_w`  in  DW: core store data.
- `d_we`  in  1: core store request, valid in EXEC.
- `d_re`  in  1: core load request, valid in EXEC.
- `d_data_r`  out  DW: load data to core.
- `cpu_en`  out  1: core retire enable; gates PC register `en` and regfile `we`.
- `x_req`  in  1: external access request.
- `x_we`  in  1: external write (1) / read (0).
- `x_addr`  in  AW: external address.
- `x_wdata`  in  DW: external write data.
- `x_rdata`  out  DW: external read data.
- `x_ack`  out  1: external access complete.
- `m_addr`  out  AW: RAM address.
- `m_data_w`  out  DW: RAM write data.
- `m_we`  out  1: RAM write strobe; write commits at the edge ending the cycle.
- `m_re`  out  1: RAM read strobe.
- `m_data_r`  in  DW: RAM read data, valid the cycle after `m_re`; held until the next `m_re`.

## Operation
- States: FETCH, LATCH, EXEC, DWAIT, XDONE. Registers: `state`, `ir`, `x_last`.
- FETCH:
  - If `x_req && !x_last`: drive `m_addr=x_addr`, `m_we=x_we`, `m_re=!x_we`, `m_data_w=x_wdata`. Set `x_last<=1` and go to XDONE.
  - Else: drive `m_addr=i_addr`, `m_re=1`. Clear `x_last<=0` and go to LATCH.
- LATCH: load `ir<=m_data_r`; go to EXEC.
- EXEC: `i_data=ir`.
  - If `d_we`: drive `m_addr=d_addr`, `m_data_w=d_data_w`, `m_we=1`, `cpu_en=1`; go to FETCH.
  - Else if `d_re`: drive `m_addr=d_addr`, `m_re=1`; go to DWAIT.
  - Else: `cpu_en=1`; go to FETCH.
  - `d_we` takes precedence if both `d_we` and `d_re` are set.
- DWAIT: `d_data_r=m_data_r`, `cpu_en=1`; go to FETCH.
- XDONE: `x_ack=1`, `x_rdata=m_data_r` (meaningful for reads only); go to FETCH.
- Fairness: after an external grant, the next FETCH always serves the core. The core therefore cannot be starved, and an external request waits at most one instruction plus one access.
- Addresses pass through unmodified; low 2 bits are not interpreted.
- Output values in states where they are not driven:
  - `m_addr`, `m_data_w` = 0; `m_we`, `m_re` = 0.
  - `d_data_r` = `m_data_r`, `x_rdata` = `m_data_r`.
  - `i_data` = `ir` in all states.

## Timing
- Core instruction latency: ALU/branch 3 cycles; store 3 cycles; load 4 cycles.
- External access: 2 cycles (FETCH grant, XDONE ack) once granted.
- `cpu_en` is high for exactly one cycle per instruction: the last one. Core state (PC, regfile) changes only at that edge.
- `ir` is stable from the cycle after LATCH until the next LATCH, so core decode and `d_addr` stay stable through EXEC/DWAIT.
- Handshake: `x_req` and all `x_*` inputs must be held from assertion until `x_ack`. The requester drops `x_req` on the edge at which it samples `x_ack`. `x_req` high in a later FETCH is a new request.
- `x_req` asserted mid-instruction is pending only; it is sampled in FETCH.
- Reset:
  - While `reset=1`, all strobes are forced 0 combinationally: `m_we`, `m_re`, `cpu_en`, `x_ack`.
  - At the edge, `state<=FETCH`, `ir<=0`, `x_last<=0`.
  - Reset mid-instruction or mid-external access aborts it with no retire and no ack. A RAM write is suppressed if reset is high in that cycle.
- First fetch occurs in the first cycle after `reset` deasserts.

## Structure
- Shared package `cpu32_pkg`:
  - State encoding enum (3 bits).
  - `AW`/`DW` default constants.
- Sub-module: the IR holding register reuses the existing `register` module, `en=(state==LATCH)`.
- Output muxing uses existing `mux2`.
- Core integration: PC `en` and regfile `we` are ANDed with `cpu_en`.

## Test plan
- Reset release, RAM[0]=0x1000_0001 (ALU op), no `x_req` -> `m_re` at cycle 0 with `m_addr=0`; `i_data=0x10000001` from cycle 2; `cpu_en` only at cycle 2.
- Store in EXEC, `d_addr=0x40`, `d_data_w=0xDEADBEEF` -> `m_we=1`, `m_addr=0x40`, `cpu_en=1` in the same cycle; RAM[0x40]=0xDEADBEEF afterwards.
- Load from 0x40 -> EXEC `m_re`, `m_addr=0x40`; DWAIT `d_data_r=0xDEADBEEF` with `cpu_en=1`; 4 cycles total.
- `x_req` read of 0x40 raised during EXEC -> granted at next FETCH; `x_ack=1`, `x_rdata=0xDEADBEEF` one cycle later.
- `x_req` held continuously with repeat requests -> grants alternate external / core-instruction; `cpu_en` pulses never stop.
- `reset` asserted in DWAIT -> no `cpu_en` pulse; state FETCH; strobes 0 during reset; next fetch from `i_addr` after release.
